// File: rtl/mem_lsq_exec_unit.sv
// rtl/mem_lsq_exec_unit.sv - load/store execution unit with committed-store buffer; optional MEM_LSQ_STORE_FWD_EN
module mem_lsq_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int TAG_WIDTH  = 6,
  parameter int LATENCY    = 2,
  parameter int SB_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic                        issue_is_store,
  input  logic [DATA_WIDTH-1:0]       issue_base,
  input  logic [DATA_WIDTH-1:0]       issue_imm,
  input  logic [DATA_WIDTH-1:0]       issue_st_data,
  input  logic [TAG_WIDTH-1:0]        issue_tag,
  input  logic                        issue_wb_valid,
  input  logic                        retire_store,
  input  logic [DATA_WIDTH-1:0]       retire_addr,
  input  logic [DATA_WIDTH-1:0]       retire_data,
  output logic                        cdb_valid,
  output logic [TAG_WIDTH-1:0]        cdb_tag,
  output logic [DATA_WIDTH-1:0]       cdb_result,
  output logic [DATA_WIDTH-1:0]       cdb_store_data,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic                        sb_overflow
);
  localparam int PW   = $clog2(SB_DEPTH);
  localparam int CW   = PW + 1;
  localparam int LAST = LATENCY - 1;

  logic [DATA_WIDTH-1:0] ea;
  logic [ADDR_WIDTH-1:0] ld_waddr;
  logic [ADDR_WIDTH-1:0] retire_waddr;
  logic                  sb_full;
  logic                  load_ok;
  logic                  accept;
  logic                  ld_accept;
  logic                  drain;
  logic                  push;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] s0_result;
  logic                  unused_bits;

  logic [ADDR_WIDTH-1:0] sb_addr [SB_DEPTH];
  logic [DATA_WIDTH-1:0] sb_data [SB_DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;

  logic                  st_valid  [LATENCY];
  logic [TAG_WIDTH-1:0]  st_tag    [LATENCY];
  logic [DATA_WIDTH-1:0] st_result [LATENCY];
  logic [DATA_WIDTH-1:0] st_sdata  [LATENCY];
  logic                  s0_load;

  assign ea           = issue_base + issue_imm;
  assign ld_waddr     = ea[ADDR_WIDTH+1:2];
  assign retire_waddr = retire_addr[ADDR_WIDTH+1:2];
  assign unused_bits  = ^{retire_addr[1:0], retire_addr[DATA_WIDTH-1:ADDR_WIDTH+2]};
  assign sb_full      = (sb_count == CW'(SB_DEPTH));

`ifdef MEM_LSQ_STORE_FWD_EN
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  s0_fwd_hit;
  logic [DATA_WIDTH-1:0] s0_fwd_data;

  // Youngest matching buffered store wins; a same-cycle retire beats the buffer
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (CW'(i) < sb_count && sb_addr[head + PW'(i)] == ld_waddr) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data[head + PW'(i)];
      end
    end
    if (retire_store && retire_waddr == ld_waddr) begin
      fwd_hit  = 1'b1;
      fwd_data = retire_data;
    end
  end

  // Forward decision travels with the load until the RAM data returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_fwd_hit  <= 1'b0;
      s0_fwd_data <= '0;
    end else begin
      s0_fwd_hit  <= ld_accept && fwd_hit;
      s0_fwd_data <= fwd_data;
    end
  end

  assign load_data = s0_fwd_hit ? s0_fwd_data : mem_rdata;
  assign load_ok   = !sb_full;
`else
  assign load_data = mem_rdata;
  assign load_ok   = (sb_count == '0) && !retire_store;
`endif

  // Loads stall behind a full buffer (or any pending store without forwarding)
  assign issue_ready = !flush && (issue_is_store || load_ok);
  assign accept      = issue_valid && issue_ready;
  assign ld_accept   = accept && !issue_is_store;
  assign drain       = (sb_count != '0) && !ld_accept;
  assign push        = retire_store && (!sb_full || drain);

  assign mem_req   = ld_accept || drain;
  assign mem_we    = drain;
  assign mem_addr  = ld_accept ? ld_waddr : (drain ? sb_addr[head] : '0);
  assign mem_wdata = drain ? sb_data[head] : '0;

  // Store-buffer payload; the head slot may be overwritten on a full push+drain
  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[tail] <= retire_waddr;
      sb_data[tail] <= retire_data;
    end
  end

  // Store-buffer pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      sb_count    <= '0;
      sb_overflow <= 1'b0;
    end else begin
      if (drain) head <= head + 1'b1;
      if (push)  tail <= tail + 1'b1;
      if (push && !drain)      sb_count <= sb_count + 1'b1;
      else if (drain && !push) sb_count <= sb_count - 1'b1;
      if (retire_store && !push) sb_overflow <= 1'b1;
    end
  end

  // Stage 0 swaps in the RAM (or forwarded) word for loads
  assign s0_result = s0_load ? load_data : st_result[0];

  // Fixed-latency result pipeline; flush kills every in-flight valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_load <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        st_valid[i]  <= 1'b0;
        st_tag[i]    <= '0;
        st_result[i] <= '0;
        st_sdata[i]  <= '0;
      end
    end else begin
      s0_load      <= !issue_is_store;
      st_valid[0]  <= accept && (issue_is_store || issue_wb_valid);
      st_tag[0]    <= issue_tag;
      st_result[0] <= ea;
      st_sdata[0]  <= issue_is_store ? issue_st_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        st_valid[i]  <= st_valid[i-1] && !flush;
        st_tag[i]    <= st_tag[i-1];
        st_result[i] <= (i == 1) ? s0_result : st_result[i-1];
        st_sdata[i]  <= st_sdata[i-1];
      end
    end
  end

  assign cdb_valid      = st_valid[LAST] && !flush;
  assign cdb_tag        = cdb_valid ? st_tag[LAST] : '0;
  assign cdb_result     = cdb_valid ? ((LATENCY == 1) ? s0_result : st_result[LAST]) : '0;
  assign cdb_store_data = cdb_valid ? st_sdata[LAST] : '0;
endmodule

// File: doc/mem_lsq_exec_unit.md
Name: mem_lsq_exec_unit

Overview:
Parametrised successor memory execution unit for the out-of-order RISC-V core. It accepts load/store issues from the ld/st issue queue and computes effective addresses. Loads read the data RAM through a single synchronous port; stores are published on the CDB at execute and written to memory only after ROB retirement, through an internal committed-store buffer. It adds store-to-load forwarding, a programmable result latency and flush of in-flight results, and sits between the ld/st issue queue, the ROB retire port and the CDB arbiter.

Parameters:
DATA_WIDTH, 32, operand/data width
ADDR_WIDTH, 7, data RAM word-address width
TAG_WIDTH, 6, ROB tag width
LATENCY, 2, issue-accept to CDB cycles; legal range 1..8
SB_DEPTH, 4, committed-store buffer entries; power of 2, minimum 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of in-flight results (mispredict)
issue_valid  in  1  issue request
issue_ready  out  1  issue accepted when valid&ready
issue_is_store  in  1  0=load, 1=store
issue_base  in  DATA_WIDTH  rs1 data
issue_imm  in  DATA_WIDTH  sign-extended immediate
issue_st_data  in  DATA_WIDTH  rs2 data
issue_tag  in  TAG_WIDTH  destination ROB tag
issue_wb_valid  in  1  load writes a register
retire_store  in  1  ROB commits oldest store
retire_addr  in  DATA_WIDTH  committed store effective address
retire_data  in  DATA_WIDTH  committed store data
cdb_valid  out  1  result valid
cdb_tag  out  TAG_WIDTH  result tag
cdb_result  out  DATA_WIDTH  load data, or store effective address
cdb_store_data  out  DATA_WIDTH  store data; 0 for loads
mem_req  out  1  RAM access this cycle
mem_we  out  1  1=write
mem_addr  out  ADDR_WIDTH  word address = ea[ADDR_WIDTH+1:2]
mem_wdata  out  DATA_WIDTH  write data
mem_rdata  in  DATA_WIDTH  read data, valid the cycle after a read request
sb_count  out  $clog2(SB_DEPTH)+1  store buffer occupancy
sb_overflow  out  1  sticky error flag

Behaviour:
- Reset: all pipeline valids, SB pointers and sb_count go to 0; sb_overflow=0; every cdb_* and mem_* output is 0.
- EA = issue_base+issue_imm, modulo 2^DATA_WIDTH. Only full-word accesses; ea[1:0] is ignored.
- Store issue: no RAM access. After LATENCY cycles: cdb_valid=1, cdb_result=EA, cdb_store_data=issue_st_data, tag passed through.
- Load issue: in the accept cycle, mem_req=1 and mem_we=0. Data is sampled at +1 and driven on the CDB at +LATENCY with cdb_valid=issue_wb_valid and cdb_store_data=0.
- Pipeline: LATENCY valid+payload stages, advancing every cycle with no back-pressure. One issue per cycle maximum.
- Store buffer (SB): a FIFO of {word addr, data}. retire_store pushes at the tail.
- SB drain: write the head entry (mem_req=1, mem_we=1) in any cycle with no accepted load. If the SB is full, drain has priority and loads see issue_ready=0. issue_ready is otherwise 1.
- Full-SB push: a push with a same-cycle drain is accepted. A push with no drain is dropped and sets sb_overflow until reset.
- Flush: clears all pipeline valids in the same cycle, so no cdb_valid is driven for anything issued at or before the flush cycle. It does not affect the SB; committed stores always drain. Issues presented in the flush cycle are not accepted (issue_ready=0).
- sb_count wraps never; range is 0..SB_DEPTH.

Optional Feature:
MEM_LSQ_STORE_FWD_EN
- Defined: a load compares its word address against all valid SB entries and the same-cycle retire_store. The youngest match wins, and the same-cycle retire has highest priority. On a hit, the forwarded data replaces mem_rdata at stage 1. The RAM read still occurs and is discarded.
- Undefined: issue_ready=0 for a load (issue_is_store=0) while sb_count!=0 or retire_store=1. Loads wait until the SB fully drains.

Test Plan:
1. Reset mid-traffic (SB holding 2 entries, load in flight) -> all outputs 0, sb_count=0, no mem_req on the following cycle.
2. Store issue base=0x100, imm=0x8, data=0xDEADBEEF, tag=5, LATENCY=2 -> 2 cycles later cdb_valid=1, tag=5, cdb_result=0x108, cdb_store_data=0xDEADBEEF; mem_req stays 0.
3. retire_store addr=0x108, data=0xDEADBEEF with an idle issue port -> next cycle mem_we=1, mem_addr=0x42, mem_wdata=0xDEADBEEF; sb_count goes 1 to 0.
4. Forwarding: retire 0x20=0x11 and load EA 0x20 in the same cycle.
   - With the macro: cdb_result=0x11 at +LATENCY.
   - Without it: issue_ready=0 until the drain completes, then the load returns 0x11 from RAM.
5. SB_DEPTH=4: fill with 4 retires, then present a load -> issue_ready=0 and a drain write occurs. A 5th retire in the drain cycle is accepted and sb_overflow stays 0. A 5th retire with no drain sets sb_overflow=1.
6. Flush one cycle after a load issue -> no cdb_valid for that load; pending SB entries still drain in order.
